tpm_op_manager: RTL

Parametrised, handshaked successor to the TPM operational-state manager. It owns the TPM lifecycle FSM: power-off, init, startup, operational, self-test, failure and shutdown. It also owns hierarchy enables and Startup/Shutdown orderly tracking. Sits between the command decoder (valid/ready in, rc out) and the execution engine (start/done), and adds a self-test watchdog and sticky failure mode.

---
 rtl/tpm_mgmt_pkg.sv | 66 ++++++
 rtl/tpm_hier_ctrl.sv | 95 +++++++++
 rtl/tpm_op_manager.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/tpm_mgmt_pkg.sv
// Shared TPM lifecycle constants, state encodings and the Startup decode.
package tpm_mgmt_pkg;

   // Command codes handled or routed by the lifecycle manager
   localparam logic [31:0] TPM_CC_HIERARCHY_CONTROL    = 32'h0000_0121;
   localparam logic [31:0] TPM_CC_INCREMENTAL_SELFTEST = 32'h0000_0142;
   localparam logic [31:0] TPM_CC_SELF_TEST            = 32'h0000_0143;
   localparam logic [31:0] TPM_CC_STARTUP              = 32'h0000_0144;
   localparam logic [31:0] TPM_CC_SHUTDOWN             = 32'h0000_0145;
   localparam logic [31:0] TPM_CC_GET_CAPABILITY       = 32'h0000_017A;
   localparam logic [31:0] TPM_CC_GET_TEST_RESULT      = 32'h0000_017C;

   // Response codes
   localparam logic [31:0] TPM_RC_SUCCESS    = 32'h0000_0000;
   localparam logic [31:0] TPM_RC_VALUE      = 32'h0000_0084;
   localparam logic [31:0] TPM_RC_INITIALIZE = 32'h0000_0100;
   localparam logic [31:0] TPM_RC_FAILURE    = 32'h0000_0101;
   localparam logic [31:0] TPM_RC_AUTH_TYPE  = 32'h0000_0124;

   // Permanent hierarchy handles
   localparam logic [31:0] TPM_RH_OWNER       = 32'h4000_0001;
   localparam logic [31:0] TPM_RH_ENDORSEMENT = 32'h4000_000B;
   localparam logic [31:0] TPM_RH_PLATFORM    = 32'h4000_000C;
   localparam logic [31:0] TPM_RH_PLATFORM_NV = 32'h4000_000D;

   // Startup/Shutdown types
   localparam logic [15:0] TPM_SU_CLEAR = 16'h0000;
   localparam logic [15:0] TPM_SU_STATE = 16'h0001;

   // Field offsets inside cmd_param
   localparam int HC_ENABLE_LSB = 1;
   localparam int HC_ENABLE_MSB = 32;
   localparam int HC_STATE_BIT  = 0;
   localparam int FULL_TEST_BIT = 0;
   localparam int SU_MSB        = 15;

   typedef enum logic [2:0] {
      OP_POWER_OFF   = 3'd0,
      OP_INIT        = 3'd1,
      OP_STARTUP     = 3'd2,
      OP_OPERATIONAL = 3'd3,
      OP_SELF_TEST   = 3'd4,
      OP_FAILURE     = 3'd5,
      OP_SHUTDOWN    = 3'd6
   } opState_t;

   typedef enum logic [2:0] {
      SU_DONE    = 3'd0,
      SU_RESET   = 3'd1,
      SU_RESTART = 3'd2,
      SU_RESUME  = 3'd3,
      SU_TYPE    = 3'd4
   } startupType_t;

   // Orderly state versus requested startup type; SU_TYPE marks an illegal pair
   function automatic startupType_t decodeStartup(input logic [15:0] orderly,
                                                  input logic [15:0] su);
      if (su == TPM_SU_CLEAR)
         return (orderly == TPM_SU_STATE) ? SU_RESTART : SU_RESET;
      else if ((su == TPM_SU_STATE) && (orderly == TPM_SU_STATE))
         return SU_RESUME;
      else
         return SU_TYPE;
   endfunction

endpackage

// File: rtl/tpm_hier_ctrl.sv
// Hierarchy enable registers, HierarchyControl decode and Startup load.
module tpm_hier_ctrl
   import tpm_mgmt_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        hcStrobe,
   input  logic        loadStrobe,
   input  logic        loadResume,
   input  logic [32:0] cmd_param,
   input  logic [31:0] auth_hierarchy,
   input  logic        nv_ph_enable_nv,
   input  logic        nv_sh_enable,
   input  logic        nv_eh_enable,
   output logic        hcAuthLocal,
   output logic [31:0] hcRc,
   output logic        ph_enable,
   output logic        ph_enable_nv,
   output logic        sh_enable,
   output logic        eh_enable
);

   logic [31:0] enableHandle;
   logic        yesNo;
   logic        phNext, phNvNext, shNext, ehNext;

   // Decode HierarchyControl into candidate enable values and its rc
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      enableHandle = cmd_param[HC_ENABLE_MSB:HC_ENABLE_LSB];
      yesNo        = cmd_param[HC_STATE_BIT];
      phNext       = ph_enable;
      phNvNext     = ph_enable_nv;
      shNext       = sh_enable;
      ehNext       = eh_enable;
      hcRc         = TPM_RC_VALUE;
      hcAuthLocal  = 1'b0;
      case (auth_hierarchy)
         TPM_RH_PLATFORM: begin
            hcAuthLocal = 1'b1;
            case (enableHandle)
               TPM_RH_ENDORSEMENT: begin ehNext   = yesNo; hcRc = TPM_RC_SUCCESS; end
               TPM_RH_OWNER:       begin shNext   = yesNo; hcRc = TPM_RC_SUCCESS; end
               TPM_RH_PLATFORM_NV: begin phNvNext = yesNo; hcRc = TPM_RC_SUCCESS; end
               TPM_RH_PLATFORM: begin
                  if (!yesNo) begin
                     phNext = 1'b0;
                     hcRc   = TPM_RC_SUCCESS;
                  end
               end
               default: hcRc = TPM_RC_VALUE;
            endcase
         end
         TPM_RH_OWNER: begin
            hcAuthLocal = 1'b1;
            hcRc        = TPM_RC_AUTH_TYPE;
            if ((enableHandle == TPM_RH_OWNER) && !yesNo) begin
               shNext = 1'b0;
               hcRc   = TPM_RC_SUCCESS;
            end
         end
         TPM_RH_ENDORSEMENT: begin
            hcAuthLocal = 1'b1;
            hcRc        = TPM_RC_AUTH_TYPE;
            if ((enableHandle == TPM_RH_ENDORSEMENT) && !yesNo) begin
               ehNext = 1'b0;
               hcRc   = TPM_RC_SUCCESS;
            end
         end
         default: hcAuthLocal = 1'b0;
      endcase
   end

   // Enable registers move only on a Startup load or a HierarchyControl strobe
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ph_enable    <= 1'b0;
         ph_enable_nv <= 1'b0;
         sh_enable    <= 1'b0;
         eh_enable    <= 1'b0;
      end else if (loadStrobe) begin
         // NOTE: non-blocking so every register samples pre-edge values together.
         ph_enable    <= 1'b1;
         ph_enable_nv <= loadResume ? nv_ph_enable_nv : 1'b1;
         sh_enable    <= loadResume ? nv_sh_enable    : 1'b1;
         eh_enable    <= loadResume ? nv_eh_enable    : 1'b1;
      end else if (hcStrobe) begin
         ph_enable    <= phNext;
         ph_enable_nv <= phNvNext;
         sh_enable    <= shNext;
         eh_enable    <= ehNext;
      end
   end

endmodule

// File: rtl/tpm_op_manager.sv
// TPM lifecycle FSM with command handshake, execution forwarding and self-test watchdog.
module tpm_op_manager
   import tpm_mgmt_pkg::*;
#(
   parameter int               NUM_TESTS         = 40,
   parameter int               TEST_W            = 16,
   parameter int               LOC_W             = 8,
   parameter logic [LOC_W-1:0] PLATFORM_LOCALITY = 8'h01,
   parameter int               TEST_TIMEOUT      = 4096
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [31:0]       tpm_cc,
   input  logic [32:0]       cmd_param,
   input  logic [31:0]       auth_hierarchy,
   input  logic [LOC_W-1:0]  locality,
   input  logic [15:0]       orderly_in,
   output logic              exec_start,
   input  logic              exec_done,
   input  logic [31:0]       exec_rc,
   input  logic              exec_initialized,
   input  logic [TEST_W-1:0] tests_run,
   input  logic [TEST_W-1:0] tests_passed,
   input  logic [TEST_W-1:0] untested,
   input  logic              nv_ph_enable_nv,
   input  logic              nv_sh_enable,
   input  logic              nv_eh_enable,
   output logic              rsp_valid,
   output logic [31:0]       tpm_rc,
   output logic [2:0]        op_state,
   output logic [2:0]        startup_type,
   output logic              ph_enable,
   output logic              ph_enable_nv,
   output logic              sh_enable,
   output logic              eh_enable,
   output logic [15:0]       shutdown_save
);

   localparam int WD_W = $clog2(TEST_TIMEOUT + 1);

   opState_t     opState;
   startupType_t startupType, suType;
   logic         pending, fullTest;
   logic [WD_W-1:0] watchdog;
   logic         accept, isStartup, isSelfTest, hcLocalCmd, hcAuthLocal;
   logic         hcStrobe, suLoad, suValid, testMismatch, testComplete;
   logic [15:0]  orderlySrc;
   logic [31:0]  hcRc;

   assign op_state     = opState;
   assign startup_type = startupType;
   assign cmd_ready    = ((opState == OP_INIT) || (opState == OP_OPERATIONAL) ||
                          (opState == OP_FAILURE) || (opState == OP_SHUTDOWN)) &&
                         !pending && !rsp_valid;

   // Classify the offered command and the self-test outcome
   always_comb begin
      accept       = cmd_valid && cmd_ready;
      isStartup    = (tpm_cc == TPM_CC_STARTUP);
      isSelfTest   = (tpm_cc == TPM_CC_SELF_TEST) || (tpm_cc == TPM_CC_INCREMENTAL_SELFTEST);
      orderlySrc   = (opState == OP_SHUTDOWN) ? shutdown_save : orderly_in;
      suType       = decodeStartup(orderlySrc, cmd_param[SU_MSB:0]);
      suValid      = (suType != SU_TYPE);
      hcLocalCmd   = (tpm_cc == TPM_CC_HIERARCHY_CONTROL) &&
                     (locality == PLATFORM_LOCALITY) && hcAuthLocal;
      suLoad       = accept && isStartup && suValid &&
                     ((opState == OP_INIT) || (opState == OP_SHUTDOWN));
      hcStrobe     = accept && (opState == OP_OPERATIONAL) && hcLocalCmd;
      testMismatch = (tests_passed != tests_run);
      testComplete = fullTest ? (tests_passed == TEST_W'(NUM_TESTS)) : (untested == '0);
   end

   tpm_hier_ctrl u_hier (
      .clock           (clock),
      .reset_n         (reset_n),
      .hcStrobe        (hcStrobe),
      .loadStrobe      (suLoad),
      .loadResume      (suType == SU_RESUME),
      .cmd_param       (cmd_param),
      .auth_hierarchy  (auth_hierarchy),
      .nv_ph_enable_nv (nv_ph_enable_nv),
      .nv_sh_enable    (nv_sh_enable),
      .nv_eh_enable    (nv_eh_enable),
      .hcAuthLocal     (hcAuthLocal),
      .hcRc            (hcRc),
      .ph_enable       (ph_enable),
      .ph_enable_nv    (ph_enable_nv),
      .sh_enable       (sh_enable),
      .eh_enable       (eh_enable)
   );

   // Lifecycle FSM with registered response, forwarding pulse and watchdog
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         opState       <= OP_POWER_OFF;
         startupType   <= SU_DONE;
         shutdown_save <= TPM_SU_CLEAR;
         tpm_rc        <= TPM_RC_SUCCESS;
         rsp_valid     <= 1'b0;
         exec_start    <= 1'b0;
         pending       <= 1'b0;
         fullTest      <= 1'b0;
         watchdog      <= '0;
      end else begin
         rsp_valid  <= 1'b0;
         exec_start <= 1'b0;
         case (opState)
            OP_POWER_OFF: opState <= OP_INIT;

            OP_INIT, OP_SHUTDOWN: begin
               if (accept) begin
                  if (isStartup) begin
                     startupType <= suType;
                     if (suValid) begin
                        opState    <= OP_STARTUP;
                        pending    <= 1'b1;
                        exec_start <= 1'b1;
                     end else begin
                        rsp_valid <= 1'b1;
                        tpm_rc    <= TPM_RC_VALUE;
                     end
                  end else begin
                     rsp_valid <= 1'b1;
                     tpm_rc    <= TPM_RC_INITIALIZE;
                  end
               end
            end

            OP_STARTUP: begin
               if (pending && exec_done) begin
                  pending   <= 1'b0;
                  rsp_valid <= 1'b1;
                  if (exec_initialized) begin
                     opState <= OP_OPERATIONAL;
                     tpm_rc  <= TPM_RC_SUCCESS;
                  end else begin
                     opState <= OP_INIT;
                     tpm_rc  <= exec_rc;
                  end
               end
            end

            OP_OPERATIONAL: begin
               if (accept) begin
                  if (hcLocalCmd) begin
                     rsp_valid <= 1'b1;
                     tpm_rc    <= hcRc;
                  end else if (isSelfTest) begin
                     opState    <= OP_SELF_TEST;
                     pending    <= 1'b1;
                     exec_start <= 1'b1;
                     fullTest   <= cmd_param[FULL_TEST_BIT];
                     watchdog   <= '0;
                  end else if (tpm_cc == TPM_CC_SHUTDOWN) begin
                     rsp_valid <= 1'b1;
                     if ((cmd_param[SU_MSB:0] == TPM_SU_CLEAR) ||
                         (cmd_param[SU_MSB:0] == TPM_SU_STATE)) begin
                        shutdown_save <= cmd_param[SU_MSB:0];
                        tpm_rc        <= TPM_RC_SUCCESS;
                        opState       <= OP_SHUTDOWN;
                     end else begin
                        tpm_rc <= TPM_RC_VALUE;
                     end
                  end else if (isStartup) begin
                     rsp_valid <= 1'b1;
                     tpm_rc    <= TPM_RC_INITIALIZE;
                  end else begin
                     pending    <= 1'b1;
                     exec_start <= 1'b1;
                  end
               end else if (pending && exec_done) begin
                  pending   <= 1'b0;
                  rsp_valid <= 1'b1;
                  tpm_rc    <= exec_rc;
               end
            end

            OP_SELF_TEST: begin
               if (pending && exec_done && testMismatch) begin
                  pending   <= 1'b0;
                  rsp_valid <= 1'b1;
                  tpm_rc    <= TPM_RC_FAILURE;
                  opState   <= OP_FAILURE;
               end else if (pending && exec_done && testComplete) begin
                  pending   <= 1'b0;
                  rsp_valid <= 1'b1;
                  tpm_rc    <= exec_rc;
                  opState   <= OP_OPERATIONAL;
               end else if (watchdog >= WD_W'(TEST_TIMEOUT - 1)) begin
                  watchdog  <= WD_W'(TEST_TIMEOUT);
                  pending   <= 1'b0;
                  rsp_valid <= 1'b1;
                  tpm_rc    <= TPM_RC_FAILURE;
                  opState   <= OP_FAILURE;
               end else begin
                  watchdog <= watchdog + 1'b1;
               end
            end

            OP_FAILURE: begin
               if (accept) begin
                  if ((tpm_cc == TPM_CC_GET_TEST_RESULT) || (tpm_cc == TPM_CC_GET_CAPABILITY)) begin
                     pending    <= 1'b1;
                     exec_start <= 1'b1;
                  end else begin
                     rsp_valid <= 1'b1;
                     tpm_rc    <= TPM_RC_FAILURE;
                  end
               end else if (pending && exec_done) begin
                  pending   <= 1'b0;
                  rsp_valid <= 1'b1;
                  tpm_rc    <= exec_rc;
               end
            end

            default: opState <= OP_FAILURE;
         endcase
      end
   end

endmodule
